// File: rtl/eth_tap_pkg.sv
// Shared types for the PCIe-tap frame scheduler: the 74-bit tap word and the
// scheduler state encoding.
package eth_tap_pkg;

  localparam int TAP_W = 74;

  typedef struct packed {
    logic       tuser;
    logic       tlast;
    logic [7:0] tkeep;
    logic [63:0] tdata;
  } tap_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DROP   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/eth_tap_sched.sv
// Frame-atomic round-robin scheduler from the CQ/CC tap FIFOs into arb2encap,
// with maximum-length truncation (tlast+tuser abort) and debug counters.
//
//  state  | meaning
//  IDLE   | no frame in flight; arbitrate between enabled, non-empty sources
//  STREAM | forwarding words of the granted source until tlast or the length limit
//  DROP   | frame was truncated; discard the remainder up to its tlast
module eth_tap_sched
  import eth_tap_pkg::*;
#(
  parameter int MAX_WORDS = 190,
  parameter int CNT_W     = 32
) (
  input  logic             clk156,
  input  logic             sys_rst_n,
  input  logic [1:0]       src_en,
  input  logic [TAP_W-1:0] fifo0_dout,
  input  logic             fifo0_empty,
  output logic             fifo0_rd_en,
  input  logic [TAP_W-1:0] fifo1_dout,
  input  logic             fifo1_empty,
  output logic             fifo1_rd_en,
  input  logic             out_afull,
  output logic             out_wr_en,
  output logic [TAP_W-1:0] out_din,
  output logic [CNT_W-1:0] frame_cnt0,
  output logic [CNT_W-1:0] frame_cnt1,
  output logic [15:0]      trunc_cnt,
  output logic             busy
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] LIMIT = WC_W'(MAX_WORDS - 1);

  sched_state_t    state, state_nxt;
  logic            sel;
  logic            last;
  logic [WC_W-1:0] word_cnt;

  logic [1:0]      req;
  logic            cur_empty;
  tap_word_t       cur_word;
  tap_word_t       fwd_word;
  logic            pop;
  logic            fwd;
  logic            grant;
  logic            gnt_src;
  logic            frame_end;
  logic            trunc;

  assign req       = src_en & ~{fifo1_empty, fifo0_empty};
  assign cur_empty = sel ? fifo1_empty : fifo0_empty;
  assign cur_word  = sel ? fifo1_dout : fifo0_dout;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fwd       = 1'b0;
    grant     = 1'b0;
    gnt_src   = 1'b0;
    frame_end = 1'b0;
    trunc     = 1'b0;
    fwd_word  = cur_word;
    case (state)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          // on a tie the source not served last time wins
          gnt_src   = (&req) ? ~last : req[1];
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        pop = ~cur_empty & ~out_afull;
        fwd = pop;
        if (pop) begin
          if (cur_word.tlast) begin
            frame_end = 1'b1;
            state_nxt = IDLE;
          end else if (word_cnt == LIMIT) begin
            frame_end      = 1'b1;
            trunc          = 1'b1;
            fwd_word.tlast = 1'b1;
            fwd_word.tuser = 1'b1;
            state_nxt      = DROP;
          end
        end
      end
      DROP: begin
        // downstream already saw the abort, so backpressure is irrelevant here
        pop = ~cur_empty;
        if (pop && cur_word.tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo0_rd_en = pop & ~sel;
  assign fifo1_rd_en = pop & sel;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel      <= 1'b0;
      last     <= 1'b1;
      word_cnt <= '0;
    end else if (grant) begin
      sel      <= gnt_src;
      last     <= gnt_src;
      word_cnt <= '0;
    end else if (fwd) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_wr_en <= 1'b0;
      out_din   <= '0;
    end else begin
      out_wr_en <= fwd;
      if (fwd) out_din <= fwd_word;
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      trunc_cnt  <= '0;
    end else begin
      if (frame_end && !sel) frame_cnt0 <= frame_cnt0 + 1'b1;
      if (frame_end && sel)  frame_cnt1 <= frame_cnt1 + 1'b1;
      if (trunc && (trunc_cnt != 16'hFFFF)) trunc_cnt <= trunc_cnt + 1'b1;
    end
  end

endmodule
